// File: rtl/lsu_mem.sv
// lsu_mem: latency-configurable load/store unit over an internal word RAM with byte-lane merging.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors instead of aligning down.
module lsu_mem #(
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);
    localparam int AW = DEPTH_LOG2 + 2;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d, err_q, err_d;
    logic [2:0]        op_q, op_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic [31:0]       mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]        lane;
    logic [31:0]       word, ld, wd;
    logic [7:0]        byte_v;
    logic [15:0]       half;
    logic [3:0]        be;
    logic              illegal, misal, err_c, commit, we_en;
    logic              unused_addr;
    assign unused_addr = ^req_addr[ADDR_W-1:AW];
    assign idx    = addr_q[AW-1:2];
    assign lane   = addr_q[1:0];
    assign word   = mem[idx];
    assign byte_v = word[{lane, 3'b000} +: 8];
    assign half   = lane[1] ? word[31:16] : word[15:0];
    assign ld     = op_q[1:0] == 2'b10 ? word
                  : op_q[1:0] == 2'b01 ? {{16{half[15] & ~op_q[2]}}, half}
                  : {{24{byte_v[7] & ~op_q[2]}}, byte_v};
    assign illegal = op_q[1:0] == 2'b11 || op_q[2:1] == 2'b11 || (we_q && op_q[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    assign misal = (op_q[1:0] == 2'b01 && addr_q[0]) || (op_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif
    assign err_c  = illegal | misal;
    assign commit = state_q == BUSY && cnt_q == 4'd0;
    assign we_en  = commit && we_q && !err_c;
    // Replicate store data across lanes so the byte enables alone select what lands.
    assign be = op_q[1:0] == 2'b00 ? 4'b0001 << lane
              : op_q[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011)
              : 4'b1111;
    assign wd = op_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}}
              : op_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}}
              : wdata_q;
    always_ff @(posedge clk) begin
        if (we_en)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = BUSY;
                cnt_d   = 4'(LATENCY - 1);
                we_d    = req_we;
                op_d    = req_op;
                addr_d  = req_addr[AW-1:0];
                wdata_d = req_wdata;
            end
            BUSY: if (cnt_q == 4'd0) begin
                state_d = RESP;
                rdata_d = (we_q || err_c) ? 32'd0 : ld;
                err_d   = err_c;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
    assign req_ready  = state_q == IDLE && !rst;
    assign resp_valid = state_q == RESP;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: directed vector table on a LATENCY=2 instance plus hand sequences for hold, latency 3 and mid-op reset.
module tb_lsu_mem;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_valid = 0, a_ready, a_we = 0, a_rvalid, a_rready = 0, a_err;
    logic [2:0]  a_op = 0;
    logic [31:0] a_addr = 0, a_wdata = 0, a_rdata;
    logic        b_valid = 0, b_ready, b_we = 0, b_rvalid, b_rready = 0, b_err;
    logic [2:0]  b_op = 0;
    logic [31:0] b_addr = 0, b_wdata = 0, b_rdata;

    lsu_mem #(.LATENCY(2)) u0 (.clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready),
        .req_we(a_we), .req_op(a_op), .req_addr(a_addr), .req_wdata(a_wdata), .resp_valid(a_rvalid),
        .resp_ready(a_rready), .resp_rdata(a_rdata), .resp_err(a_err));
    lsu_mem #(.LATENCY(3)) u1 (.clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
        .req_we(b_we), .req_op(b_op), .req_addr(b_addr), .req_wdata(b_wdata), .resp_valid(b_rvalid),
        .resp_ready(b_rready), .resp_rdata(b_rdata), .resp_err(b_err));

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr, wdata, rdata;
        logic        err;
    } vec_t;
    vec_t vt[$];
    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
        vt.push_back('{we, op, addr, wdata, rdata, err});
    endfunction

    task automatic a_txn(input logic we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic err, output int lat);
        @(negedge clk);
        a_valid = 1; a_we = we; a_op = op; a_addr = addr; a_wdata = wdata; a_rready = 1;
        for (int k = 0; k < 20 && !a_ready; k++) @(negedge clk);
        @(posedge clk); #1 a_valid = 0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1 lat++;
            if (a_rvalid) break;
        end
        rd = a_rdata; err = a_err;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        add(1, 3'b010, 32'h00, 32'h0BADF00D, 32'h0, 0);
        add(0, 3'b010, 32'h00, 32'h0, 32'h0BADF00D, 0);
        add(0, 3'b011, 32'h00, 32'h0, 32'h0, 1);
        add(1, 3'b100, 32'h00, 32'hFFFFFFFF, 32'h0, 1);
        add(1, 3'b101, 32'h00, 32'hFFFFFFFF, 32'h0, 1);
        add(0, 3'b110, 32'h00, 32'h0, 32'h0, 1);
        add(1, 3'b111, 32'h00, 32'hFFFFFFFF, 32'h0, 1);
        add(0, 3'b010, 32'h00, 32'h0, 32'h0BADF00D, 0);
        add(1, 3'b010, 32'h10, 32'h876580F1, 32'h0, 0);
        add(0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFF1, 0);
        add(0, 3'b100, 32'h10, 32'h0, 32'h000000F1, 0);
        add(0, 3'b001, 32'h12, 32'h0, 32'hFFFF8765, 0);
        add(0, 3'b101, 32'h12, 32'h0, 32'h00008765, 0);
        add(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF87, 0);
        add(0, 3'b100, 32'h11, 32'h0, 32'h00000080, 0);
        add(1, 3'b010, 32'h20, 32'h11223344, 32'h0, 0);
        add(1, 3'b000, 32'h21, 32'h123456AA, 32'h0, 0);
        add(1, 3'b001, 32'h22, 32'hFFFFBEEF, 32'h0, 0);
        add(0, 3'b010, 32'h20, 32'h0, 32'hBEEFAA44, 0);
        add(0, 3'b010, 32'h22, 32'h0, TRAP ? 32'h0 : 32'hBEEFAA44, TRAP);
        add(0, 3'b001, 32'h21, 32'h0, TRAP ? 32'h0 : 32'hFFFFAA44, TRAP);
        add(0, 3'b101, 32'h23, 32'h0, TRAP ? 32'h0 : 32'h0000BEEF, TRAP);
        add(1, 3'b010, 32'h23, 32'h77777777, 32'h0, TRAP);
        add(0, 3'b010, 32'h20, 32'h0, TRAP ? 32'hBEEFAA44 : 32'h77777777, 0);
        add(1, 3'b010, 32'h1000, 32'hCAFEBABE, 32'h0, 0);
        add(0, 3'b010, 32'h00, 32'h0, 32'hCAFEBABE, 0);
        add(1, 3'b001, 32'h1002, 32'h55551234, 32'h0, 0);
        add(0, 3'b010, 32'h00, 32'h0, 32'h1234BABE, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", 32'(a_ready), 32'd0);
        chk("rst resp_valid", 32'(a_rvalid), 32'd0);
        chk("rst rdata", a_rdata, 32'd0);
        chk("rst err", 32'(a_err), 32'd0);
        rst = 0;
        @(posedge clk); #1;
        chk("post-rst req_ready", 32'(a_ready), 32'd1);

        foreach (vt[i]) begin
            a_txn(vt[i].we, vt[i].op, vt[i].addr, vt[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d rdata", i), rd, vt[i].rdata);
            chk($sformatf("vec%0d err", i), 32'(er), 32'(vt[i].err));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
        end

        // LATENCY=3 instance: latency, stall hold, release
        @(negedge clk);
        b_valid = 1; b_we = 1; b_op = 3'b010; b_addr = 32'h4; b_wdata = 32'h5A5A5A5A; b_rready = 1;
        @(posedge clk); #1 b_valid = 0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1 lat++;
            if (b_rvalid) break;
        end
        chk("l3 store latency", 32'(lat), 32'd3);
        @(posedge clk); #1;
        @(negedge clk);
        b_valid = 1; b_we = 0; b_op = 3'b010; b_addr = 32'h4; b_rready = 0;
        @(posedge clk); #1 b_valid = 0;
        chk("l3 busy req_ready", 32'(b_ready), 32'd0);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1 lat++;
            if (b_rvalid) break;
        end
        chk("l3 load latency", 32'(lat), 32'd3);
        chk("l3 load rdata", b_rdata, 32'h5A5A5A5A);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d valid", k), 32'(b_rvalid), 32'd1);
            chk($sformatf("hold%0d rdata", k), b_rdata, 32'h5A5A5A5A);
            chk($sformatf("hold%0d req_ready", k), 32'(b_ready), 32'd0);
        end
        b_rready = 1;
        @(posedge clk); #1;
        chk("l3 post-hs valid", 32'(b_rvalid), 32'd0);
        chk("l3 post-hs req_ready", 32'(b_ready), 32'd1);

        // reset one cycle after accept aborts the store
        a_txn(1, 3'b010, 32'h40, 32'h11111111, rd, er, lat);
        @(negedge clk);
        a_valid = 1; a_we = 1; a_op = 3'b010; a_addr = 32'h40; a_wdata = 32'hDEADBEEF; a_rready = 1;
        @(posedge clk); #1 a_valid = 0;
        @(posedge clk); #1 rst = 1;
        #1;
        chk("midrst req_ready", 32'(a_ready), 32'd0);
        chk("midrst resp_valid", 32'(a_rvalid), 32'd0);
        @(negedge clk) rst = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("midrst no resp%0d", k), 32'(a_rvalid), 32'd0);
        end
        a_txn(0, 3'b010, 32'h40, 32'h0, rd, er, lat);
        chk("midrst old data", rd, 32'h11111111);
        chk("midrst old err", 32'(er), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
